avalon_pio_out_pulse: RTL and testbench

Parametrised Avalon-MM slave output port that drives a `WIDTH`-bit `out_port` from a CPU-writable register. It adds atomic set and clear registers and a self-clearing timed pulse register, so software can assert a line such as a peripheral reset for an exact cycle count without polling. It sits on the system interconnect as a drop-in successor to the single-bit output PIOs (USB reset and similar control lines).

---
 rtl/pio_pkg.sv | 19 +
 rtl/pio_pulse_timer.sv | 38 +++
 rtl/avalon_pio_out_pulse.sv | 117 +++++++++++
 tb/tb_avalon_pio_out_pulse.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register map and helpers for the Avalon PIO output blocks.
// The pulse feature is compiled in only when PIO_PULSE_EN is defined.
package pio_pkg;

  typedef enum logic [1:0] {
    PIO_OFS_DATA  = 2'd0,
    PIO_OFS_SET   = 2'd1,
    PIO_OFS_CLR   = 2'd2,
    PIO_OFS_PULSE = 2'd3
  } pio_ofs_e;

  localparam int PIO_BUSY_BIT = 31;

  // Counter width for a timer loaded with cycles-1; never narrower than one bit.
  function automatic int pio_cnt_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// Reloadable down-counter that times one output pulse and strobes expire
// in the cycle its count reaches zero; it then idles at zero until restarted.
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int PULSE_CYCLES = 1000,
  parameter int CNT_W        = pio_cnt_width(PULSE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_CYCLES - 1);

  assign expire = busy && (count == '0);

  // A start in the expiry cycle takes priority, so a back-to-back pulse restarts cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= RELOAD;
    end else if (busy) begin
      if (count == '0) begin
        busy <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output PIO with DATA/SET/CLEAR registers and, when PIO_PULSE_EN
// is defined, a self-clearing timed PULSE register at offset 3.
module avalon_pio_out_pulse
  import pio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               PULSE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             write_en;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_next;
  logic             unused_wdata;

  assign write_en     = chipselect && !write_n;
  assign wmask        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign out_port     = data_out;

`ifdef PIO_PULSE_EN
  localparam int CNT_W = pio_cnt_width(PULSE_CYCLES);

  logic [WIDTH-1:0] pulse_mask;
  logic [WIDTH-1:0] mask_next;
  logic             start;
  logic             busy;
  logic             expire;
  logic [CNT_W-1:0] count;

  assign start = write_en && (address == PIO_OFS_PULSE) && (wmask != '0);

  pio_pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .busy   (busy),
    .count  (count),
    .expire (expire)
  );
`endif

  // Expiry is folded in first so a same-cycle bus write sees the post-expiry value.
  always_comb begin
    data_next = data_out;
`ifdef PIO_PULSE_EN
    mask_next = pulse_mask;
    if (expire) begin
      data_next = data_next & ~pulse_mask;
      mask_next = '0;
    end
`endif
    if (write_en) begin
      case (address)
        PIO_OFS_DATA: data_next = wmask;
        PIO_OFS_SET:  data_next = data_next | wmask;
        PIO_OFS_CLR:  data_next = data_next & ~wmask;
`ifdef PIO_PULSE_EN
        PIO_OFS_PULSE: begin
          if (wmask != '0) begin
            data_next = (data_next & ~pulse_mask) | wmask;
            mask_next = wmask;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
    end else begin
      data_out <= data_next;
    end
  end

`ifdef PIO_PULSE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_mask <= '0;
    end else begin
      pulse_mask <= mask_next;
    end
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      PIO_OFS_DATA: readdata[WIDTH-1:0] = data_out;
`ifdef PIO_PULSE_EN
      PIO_OFS_SET:  readdata[WIDTH-1:0] = pulse_mask;
      PIO_OFS_PULSE: begin
        readdata[CNT_W-1:0]     = count;
        readdata[PIO_BUSY_BIT]  = busy;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Scoreboard bench for avalon_pio_out_pulse: a deadline-based reference model
// predicts out_port and readdata for every cycle; a monitor compares them.
module tb_avalon_pio_out_pulse;

  localparam int         W   = 8;
  localparam int         P   = 5;
  localparam logic [7:0] RV  = 8'hA5;
`ifdef PIO_PULSE_EN
  localparam bit         PEN = 1'b1;
`else
  localparam bit         PEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  typedef struct {
    logic [7:0]  out_v;
    logic [31:0] rd_v;
    int          edge_v;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: a pulse written at edge k clears its bits at edge k+P.
  logic [7:0] m_data;
  logic [7:0] m_mask;
  bit         m_busy;
  int         m_deadline;
  int         edge_no;

  avalon_pio_out_pulse #(
    .WIDTH       (W),
    .PULSE_CYCLES(P),
    .RESET_VALUE (RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    m_data     = RV;
    m_mask     = '0;
    m_busy     = 1'b0;
    m_deadline = 0;
  endfunction

  function automatic void modelEdge(input bit wr, input logic [1:0] addr, input logic [7:0] m);
    if (m_busy && edge_no == m_deadline) begin
      m_data = m_data & ~m_mask;
      m_mask = '0;
      m_busy = 1'b0;
    end
    if (wr) begin
      case (addr)
        2'd0: m_data = m;
        2'd1: m_data = m_data | m;
        2'd2: m_data = m_data & ~m;
        default: begin
          if (PEN && m != 8'h00) begin
            m_data     = (m_data & ~m_mask) | m;
            m_mask     = m;
            m_busy     = 1'b1;
            m_deadline = edge_no + P;
          end
        end
      endcase
    end
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] addr);
    case (addr)
      2'd0:    return {24'h0, m_data};
      2'd1:    return PEN ? {24'h0, m_mask} : 32'h0;
      2'd2:    return 32'h0;
      default: return (PEN && m_busy) ? (32'h8000_0000 | 32'(m_deadline - 1 - edge_no)) : 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int edge_v,
                             input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s edge %0d got %h expected %h", name, edge_v, got, expv);
    end
  endtask

  // Drives one bus cycle on the falling edge and queues the post-edge prediction.
  task automatic applyStimulus(input bit cs, input bit wr, input logic [1:0] addr,
                               input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    chipselect = cs;
    write_n    = !wr;
    address    = addr;
    writedata  = wd;
    edge_no++;
    modelEdge(cs && wr, addr, wd[7:0]);
    e.out_v  = m_data;
    e.rd_v   = modelRead(addr);
    e.edge_v = edge_no;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [1:0] addr, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, addr, $urandom);
  endtask

  initial begin : monitor
    exp_t cur;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        checkOutput("out_port", cur.edge_v, 32'(out_port), 32'(cur.out_v));
        checkOutput("readdata", cur.edge_v, readdata, cur.rd_v);
      end
    end
  end

  initial begin : stimulus
    bit          cs, wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    int          wait_cycles;

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    edge_no    = 0;
    modelReset();

    #12;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      checkOutput("reset_out_port", 0, 32'(out_port), 32'(RV));
      checkOutput("reset_readdata", 0, readdata, modelRead(2'(a)));
    end
    @(negedge clk);
    reset_n = 1'b1;

    // DATA, SET, CLEAR stepping.
    applyStimulus(1, 1, 2'd0, 32'h0000_000F);
    applyStimulus(1, 1, 2'd1, 32'hFFFF_FFF0);
    applyStimulus(1, 1, 2'd2, 32'h0000_003C);
    idle(2'd0, 1);

    // Single pulse, watching the counter.
    applyStimulus(1, 1, 2'd0, 32'h0);
    applyStimulus(1, 1, 2'd3, 32'h0000_0001);
    idle(2'd3, P + 2);

    // Overlap: SET mid-pulse, CLEAR landing in the expiry cycle.
    applyStimulus(1, 1, 2'd0, 32'h0000_0040);
    applyStimulus(1, 1, 2'd3, 32'h0000_0003);
    idle(2'd1, 1);
    applyStimulus(1, 1, 2'd1, 32'h0000_0001);
    idle(2'd3, P - 3);
    applyStimulus(1, 1, 2'd2, 32'h0000_0002);
    idle(2'd0, 2);

    // Re-pulse while busy.
    applyStimulus(1, 1, 2'd3, 32'h0000_0001);
    idle(2'd3, 1);
    applyStimulus(1, 1, 2'd3, 32'h0000_0002);
    idle(2'd3, P + 1);

    // Zero-mask and full-mask pulse writes.
    applyStimulus(1, 1, 2'd3, 32'h0);
    applyStimulus(1, 1, 2'd3, 32'h0000_00FF);
    idle(2'd1, 2);

    // Reset in the middle of that pulse; nothing may resume afterwards.
    @(negedge clk);
    reset_n    = 1'b0;
    chipselect = 1'b0;
    address    = 2'd3;
    modelReset();
    #1;
    checkOutput("midreset_out_port", edge_no, 32'(out_port), 32'(RV));
    checkOutput("midreset_busy", edge_no, readdata, modelRead(2'd3));
    @(negedge clk);
    reset_n = 1'b1;
    idle(2'd3, P + 2);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cs   = ($urandom_range(0, 9) < 6);
      wr   = ($urandom_range(0, 9) < 4);
      addr = 2'($urandom_range(0, 3));
      wd   = $urandom;
      if ($urandom_range(0, 5) == 0) wd = wd & 32'hFFFF_FF00;
      applyStimulus(cs, wr, addr, wd);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
